// File: rtl/instr_loader.sv
// Boot-time program loader: receives a little-endian word count and then that
// many little-endian 32-bit words over a byte stream, writes them to
// instruction memory, answers with one status byte and releases the core.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  core_rst,
  output logic                  loading,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_ACK,
    S_ERR,
    S_RUN
  } state_e;

  // Capacity is kept one bit wider than the 32-bit count so the full header
  // can be compared without truncation.
  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

  state_e                state_q;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q;
  logic [31:0]           word_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  capture_en;
  logic                  byte_last;

  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic                  core_rst_q;
  logic                  loading_q;
  logic                  err_q;

  // Byte capture is only live while a header or payload is being received.
  always_comb begin
    capture_en = rx_valid && ((state_q == S_LEN) || (state_q == S_DATA));
    byte_last  = capture_en && (byte_cnt_q == 2'd3);
    byte_cnt_d = byte_cnt_q + 2'd1;
    word_d     = {rx_data, asm_q};
    word_cnt_d = word_cnt_q + 1'b1;
  end

  // Byte assembler: lower three bytes are stored, the fourth is used directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else if (capture_en) begin
      byte_cnt_q <= byte_cnt_d;
      case (byte_cnt_q)
        2'd0:    asm_q[7:0]   <= rx_data;
        2'd1:    asm_q[15:8]  <= rx_data;
        2'd2:    asm_q[23:16] <= rx_data;
        default: asm_q        <= asm_q;
      endcase
    end
  end

  // Load sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LEN;
      word_cnt_q   <= '0;
      len_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      core_rst_q   <= 1'b1;
      loading_q    <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_LEN: begin
          if (byte_last) begin
            len_q      <= word_d[ADDR_WIDTH:0];
            word_cnt_q <= '0;
            if (word_d == '0) begin
              state_q    <= S_ACK;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ACK_BYTE;
              loading_q  <= 1'b0;
            end else if ({1'b0, word_d} > CAPACITY) begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ERR_BYTE;
              loading_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (byte_last) begin
            imem_we_q    <= 1'b1;
            imem_wdata_q <= word_d;
            imem_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
            word_cnt_q   <= word_cnt_d;
            // Leave on the same edge that raises the final write pulse.
            if (word_cnt_d == len_q) begin
              state_q    <= S_ACK;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ACK_BYTE;
              loading_q  <= 1'b0;
            end
          end
        end
        S_ACK: begin
          if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_ERR: begin
          // ERR_BYTE is raised only on entry, so it is presented exactly once.
          if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
          end
        end
        S_RUN: begin
          core_rst_q <= 1'b0;
        end
        default: begin
          state_q <= S_LEN;
        end
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign core_rst   = core_rst_q;
  assign loading    = loading_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader; expected writes and TX bytes go into
// queues and a negedge monitor checks them as the DUT produces them.
module tb_instr_loader;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          core_rst;
  logic          loading;
  logic          err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_we_cyc = -1;
  int prev_we_cyc = -1;
  int tx_seen = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [7:0]    exp_tx_q[$];

  instr_loader #(
    .ADDR_WIDTH(AW),
    .ACK_BYTE  (8'hAA),
    .ERR_BYTE  (8'hEE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .core_rst  (core_rst),
    .loading   (loading),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        prev_we_cyc = last_we_cyc;
        last_we_cyc = cyc;
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          check("write_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
          check("write_data", imem_wdata, exp_data_q.pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        tx_seen++;
        if (exp_tx_q.size() == 0) begin
          check("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
          check("core_rst_at_handshake", 32'(core_rst), 32'd1);
        end
      end
    end
  end

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Called at posedge+1; leaves at posedge+1.
  task automatic send(input logic [7:0] b, input bit gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((exp_addr_q.size() + exp_tx_q.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(exp_addr_q.size() + exp_tx_q.size()), 32'd0);
  endtask

  task automatic wait_core_run(input string name);
    int n = 0;
    while (core_rst && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(core_rst), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_imem_wdata", imem_wdata,      32'd0);
    check("rst_tx_valid",   32'(tx_valid),   32'd0);
    check("rst_tx_data",    32'(tx_data),    32'd0);
    check("rst_core_rst",   32'(core_rst),   32'd1);
    check("rst_err",        32'(err),        32'd0);
    check("rst_loading",    32'(loading),    32'd1);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_tx_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;

    // 1: basic two-word load
    do_reset();
    expect_write(4'd0, 32'h00A0_0513);
    expect_write(4'd1, 32'h0000_006F);
    exp_tx_q.push_back(8'hAA);
    send_word(32'h0000_0002, 1'b1);
    check("t1_loading_data", 32'(loading), 32'd1);
    send_word(32'h00A0_0513, 1'b1);
    send_word(32'h0000_006F, 1'b1);
    wait_drained("t1_drained");
    wait_core_run("t1_core_run");
    check("t1_err", 32'(err), 32'd0);
    check("t1_loading", 32'(loading), 32'd0);

    // asynchronous reset re-holds the core before the next edge
    #2 rst = 1'b1;
    #1 check("async_core_rst", 32'(core_rst), 32'd1);
    check("async_loading", 32'(loading), 32'd1);

    // 2: zero-length program
    do_reset();
    exp_tx_q.push_back(8'hAA);
    send_word(32'h0000_0000, 1'b1);
    wait_drained("t2_drained");
    wait_core_run("t2_core_run");

    // 3: length one past capacity
    do_reset();
    exp_tx_q.push_back(8'hEE);
    send_word(32'(17), 1'b1);
    wait_drained("t3_drained");
    check("t3_err", 32'(err), 32'd1);
    send_word(32'h1234_5678, 1'b0);
    send_word(32'h9ABC_DEF0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("t3_core_rst", 32'(core_rst), 32'd1);
    check("t3_err_sticky", 32'(err), 32'd1);
    check("t3_tx_idle", 32'(tx_valid), 32'd0);

    // 3b: large header whose low bits alone would fit
    do_reset();
    exp_tx_q.push_back(8'hEE);
    send_word(32'h0100_0001, 1'b1);
    wait_drained("t3b_drained");
    check("t3b_err", 32'(err), 32'd1);

    // 4: twelve bytes back to back
    do_reset();
    expect_write(4'd0, 32'h1122_3344);
    expect_write(4'd1, 32'hDEAD_BEEF);
    exp_tx_q.push_back(8'hAA);
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_drained("t4_drained");
    check("t4_we_spacing", 32'(last_we_cyc - prev_we_cyc), 32'd4);
    wait_core_run("t4_core_run");

    // 5: TX stalled for ten cycles
    do_reset();
    tx_ready = 1'b0;
    expect_write(4'd0, 32'hCAFE_F00D);
    exp_tx_q.push_back(8'hAA);
    send_word(32'h0000_0001, 1'b1);
    send_word(32'hCAFE_F00D, 1'b1);
    begin
      int n = 0;
      while (!tx_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_tx_valid_hold", 32'(tx_valid), 32'd1);
      check("t5_tx_data_hold", 32'(tx_data), 32'hAA);
      check("t5_core_rst_hold", 32'(core_rst), 32'd1);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drained("t5_drained");
    wait_core_run("t5_core_run");

    // full-capacity load, last address 2**AW-1
    do_reset();
    for (int i = 0; i < 16; i++) expect_write(AW'(i), 32'hA500_0000 | 32'(i * 3));
    exp_tx_q.push_back(8'hAA);
    send_word(32'(16), 1'b0);
    for (int i = 0; i < 16; i++) send_word(32'hA500_0000 | 32'(i * 3), 1'b0);
    wait_drained("cap_drained");
    wait_core_run("cap_core_run");
    check("cap_err", 32'(err), 32'd0);

    // 6: reset in the middle of a load, then a fresh one-word load
    do_reset();
    send_word(32'h0000_0003, 1'b1);
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    check("t6_loading_mid", 32'(loading), 32'd1);
    do_reset();
    base = tx_seen;
    expect_write(4'd0, 32'h1234_5678);
    exp_tx_q.push_back(8'hAA);
    send_word(32'h0000_0001, 1'b1);
    send_word(32'h1234_5678, 1'b1);
    wait_drained("t6_drained");
    repeat (20) @(posedge clk);
    #1;
    check("t6_one_ack", 32'(tx_seen - base), 32'd1);
    check("t6_core_run", 32'(core_rst), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
